// File: rtl/seq_loader_if.sv
// Byte-stream input, ring load strobe and status of the sequence loader.
// master = stream source / status observer, slave = seq_loader.
interface seq_loader_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             in_last;
  logic             s_valid;
  logic [1:0]       s_symbol;
  logic             busy;
  logic             done;
  logic [CNT_W:0]   seq_len;
  logic             err_char;
  logic             err_len;

  modport master (
    output start, in_valid, in_char, in_last,
    input  in_ready, s_valid, s_symbol, busy, done, seq_len, err_char, err_len
  );

  modport slave (
    input  start, in_valid, in_char, in_last,
    output in_ready, s_valid, s_symbol, busy, done, seq_len, err_char, err_len
  );
endinterface

// File: rtl/seq_loader.sv
// Buffers one ASCII base sequence as 2-bit symbols, then fills the symbol ring with REG_NUM
// gap-free strobes. Define SEQ_LOADER_CHK_EN to flag and zero non-ACGT bytes.
module seq_loader #(
  parameter int REG_NUM = 128,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         reset,
  seq_loader_if.slave bus
);
  localparam int             AW    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(REG_NUM);
  localparam logic [CNT_W:0] LAST  = (CNT_W+1)'(REG_NUM - 1);
  localparam logic [CNT_W:0] ONE   = (CNT_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

  state_t         state_q, state_d;
  logic [CNT_W:0] wrIdx_q, wrIdx_d;
  logic [CNT_W:0] rdIdx_q, rdIdx_d;
  logic [CNT_W:0] seqLen_q, seqLen_d;
  logic           errChar_q, errChar_d;
  logic           errLen_q, errLen_d;
  logic           sValid_q, sValid_d;
  logic [1:0]     sSymbol_q, sSymbol_d;
  logic [1:0]     buf_q [REG_NUM];

  logic           handshake;
  logic           charBad;
  logic [1:0]     charCode;
  logic [CNT_W:0] wrNext;
  logic [CNT_W:0] rdNext;

  assign handshake = bus.in_valid && (state_q == FILL);
  assign wrNext    = wrIdx_q + ONE;
  assign rdNext    = rdIdx_q + ONE;

  always_comb begin
    charCode = 2'b00;
    charBad  = 1'b0;
    case (bus.in_char)
      8'h41, 8'h61: charCode = 2'b00;
      8'h43, 8'h63: charCode = 2'b01;
      8'h47, 8'h67: charCode = 2'b10;
      8'h54, 8'h74: charCode = 2'b11;
      default: begin
`ifdef SEQ_LOADER_CHK_EN
        charCode = 2'b00;
        charBad  = 1'b1;
`else
        charCode = bus.in_char[2:1];
`endif
      end
    endcase
  end

  // Symbol 0 of a length-1 sequence is written on the same edge it is first emitted, so bypass it.
  always_comb begin
    state_d   = state_q;
    wrIdx_d   = wrIdx_q;
    rdIdx_d   = rdIdx_q;
    seqLen_d  = seqLen_q;
    errChar_d = errChar_q;
    errLen_d  = errLen_q;
    sValid_d  = 1'b0;
    sSymbol_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = FILL;
          wrIdx_d   = '0;
          errChar_d = 1'b0;
          errLen_d  = 1'b0;
        end
      end
      FILL: begin
        if (handshake) begin
          wrIdx_d = wrNext;
          if (charBad) errChar_d = 1'b1;
          if (bus.in_last || (wrNext == DEPTH)) begin
            state_d   = BURST;
            seqLen_d  = wrNext;
            rdIdx_d   = '0;
            errLen_d  = errLen_q | ~bus.in_last;
            sValid_d  = 1'b1;
            sSymbol_d = (wrIdx_q == '0) ? charCode : buf_q[0];
          end
        end
      end
      BURST: begin
        if (rdIdx_q == LAST) begin
          state_d = DONE;
        end else begin
          rdIdx_d   = rdNext;
          sValid_d  = 1'b1;
          sSymbol_d = (rdNext < seqLen_q) ? buf_q[rdNext[AW-1:0]] : 2'b00;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wrIdx_q   <= '0;
      rdIdx_q   <= '0;
      seqLen_q  <= '0;
      errChar_q <= 1'b0;
      errLen_q  <= 1'b0;
      sValid_q  <= 1'b0;
      sSymbol_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      wrIdx_q   <= wrIdx_d;
      rdIdx_q   <= rdIdx_d;
      seqLen_q  <= seqLen_d;
      errChar_q <= errChar_d;
      errLen_q  <= errLen_d;
      sValid_q  <= sValid_d;
      sSymbol_q <= sSymbol_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (handshake) buf_q[wrIdx_q[AW-1:0]] <= charCode;
  end

  assign bus.in_ready = (state_q == FILL);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.s_valid  = sValid_q;
  assign bus.s_symbol = sSymbol_q;
  assign bus.seq_len  = seqLen_q;
  assign bus.err_char = errChar_q;
  assign bus.err_len  = errLen_q;
endmodule

// File: tb/tb_seq_loader.sv
// Scoreboard bench for seq_loader with an 8-entry ring; honours SEQ_LOADER_CHK_EN.
module tb_seq_loader;
  localparam int REG_NUM = 8;
  localparam int CNT_W   = 3;
`ifdef SEQ_LOADER_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    int len;
    int errChar;
    int errLen;
  } load_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   doneCnt = 0;
  int   strobeCnt = 0;
  logic prevValid = 1'b0;
  int   expSym[$];
  load_t expLoad[$];

  seq_loader_if #(.CNT_W(CNT_W)) bus ();

  seq_loader #(.REG_NUM(REG_NUM), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Eight symbols packed first-symbol-in-MSBs.
  task automatic pushExpected(input logic [15:0] syms, input int len, input int ec, input int el);
    load_t l;
    for (int i = 0; i < REG_NUM; i++) expSym.push_back(int'(syms[15-2*i -: 2]));
    l.len = len;
    l.errChar = ec;
    l.errLen = el;
    expLoad.push_back(l);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      expSym.delete();
      expLoad.delete();
      strobeCnt = 0;
      prevValid = 1'b0;
    end else begin
      if (bus.s_valid) begin
        strobeCnt++;
        if (expSym.size() == 0) checkOutput("unexpected_strobe", 1, 0);
        else checkOutput("s_symbol", int'(bus.s_symbol), expSym.pop_front());
      end
      if (prevValid && !bus.s_valid && !bus.done) checkOutput("burst_gap", 0, 1);
      if (bus.done) begin
        load_t l;
        doneCnt++;
        checkOutput("strobe_count", strobeCnt, REG_NUM);
        checkOutput("done_after_last_strobe", int'(prevValid), 1);
        if (expLoad.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          l = expLoad.pop_front();
          checkOutput("seq_len", int'(bus.seq_len), l.len);
          checkOutput("err_char", int'(bus.err_char), l.errChar);
          checkOutput("err_len", int'(bus.err_len), l.errLen);
        end
        strobeCnt = 0;
      end
      prevValid = bus.s_valid;
    end
  end

  task automatic startLoad();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input string s, input bit withLast, input bit toggle);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      if (toggle) begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_char  = s[i];
      bus.in_last  = withLast && (i == s.len() - 1);
      n = 0;
      while (!bus.in_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("in_ready_fill", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 60);
    checkOutput("done_seen", int'(bus.done), 1);
  endtask

  initial begin
    int snap;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", int'(bus.in_ready), 0);
    checkOutput("rst_s_valid", int'(bus.s_valid), 0);
    checkOutput("rst_s_symbol", int'(bus.s_symbol), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_seq_len", int'(bus.seq_len), 0);
    checkOutput("rst_err_char", int'(bus.err_char), 0);
    checkOutput("rst_err_len", int'(bus.err_len), 0);
    #1 reset = 1'b0;

    // Reset in the middle of a burst
    startLoad();
    pushExpected(16'hA000, 2, 0, 0);
    applyStimulus("GG", 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pre_s_valid", int'(bus.s_valid), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_s_valid", int'(bus.s_valid), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    snap = doneCnt;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", doneCnt - snap, 0);
    checkOutput("abort_idle_s_valid", int'(bus.s_valid), 0);

    // Plain "ACGT" load
    startLoad();
    @(negedge clk);
    checkOutput("fill_busy", int'(bus.busy), 1);
    checkOutput("fill_in_ready", int'(bus.in_ready), 1);
    pushExpected(16'h1B00, 4, 0, 0);
    applyStimulus("ACGT", 1'b1, 1'b0);
    waitDone();
    @(negedge clk);
    checkOutput("done_one_cycle", int'(bus.done), 0);
    checkOutput("idle_busy", int'(bus.busy), 0);

    // in_valid toggling during fill
    startLoad();
    pushExpected(16'h1B00, 4, 0, 0);
    applyStimulus("ACGT", 1'b1, 1'b1);
    waitDone();

    // Non-ACGT byte, plus a start pulse during the burst
    startLoad();
    pushExpected(16'h0800, 3, CHK, 0);
    applyStimulus("AXg", 1'b1, 1'b0);
    checkOutput("burst_in_ready", int'(bus.in_ready), 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone();
    @(negedge clk);
    checkOutput("start_in_burst_ignored_busy", int'(bus.busy), 0);
    checkOutput("start_in_burst_ignored_ready", int'(bus.in_ready), 0);

    // Overlong sequence: ninth byte must be refused
    startLoad();
    pushExpected(16'h1B1B, 8, 0, 1);
    applyStimulus("ACGTACGT", 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_char  = "A";
    @(negedge clk);
    checkOutput("full_in_ready", int'(bus.in_ready), 0);
    checkOutput("full_err_len", int'(bus.err_len), 1);
    checkOutput("full_busy", int'(bus.busy), 1);
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    waitDone();

    // Back-to-back load right after done clears the sticky flags
    startLoad();
    @(negedge clk);
    checkOutput("b2b_in_ready", int'(bus.in_ready), 1);
    checkOutput("b2b_err_len", int'(bus.err_len), 0);
    checkOutput("b2b_err_char", int'(bus.err_char), 0);
    pushExpected(16'hE400, 4, 0, 0);
    applyStimulus("TGCA", 1'b1, 1'b0);
    waitDone();
    repeat (2) @(negedge clk);
    checkOutput("leftover_symbols", expSym.size(), 0);
    checkOutput("leftover_loads", expLoad.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
